f2s_bram_fill_ctrl: RTL and testbench
=====================================

# f2s_bram_fill_ctrl

Stream-to-BRAM ping-pong fill controller on the FPGA side of the f2s stream path. It accepts a valid/ready word stream and writes it into a dual-half BRAM. It publishes per-half "full" levels and a sticky overflow bit on a 32-bit status bus that drives the IRQ-capable PIO `in_port`, whose rising-edge capture interrupts the HPS. The HPS acknowledges halves through the PIO `out_port`, which drives this block's `ctrl` input.

## Interface
- `ADDR_W`, 10: BRAM word-address width. Depth is 2^ADDR_W; each half is 2^(ADDR_W-1) words. Legal range 2..16.
- `DATA_W`, 32: stream and BRAM data width.

- `clk` in 1: single clock for all logic.
- `reset_n` in 1: reset, synchronous and active-low.
- `ctrl` in 32: from PIO `out_port`.
  - bit0 `enable`: level.
  - bit1 `ack0`: rising edge acks half 0.
  - bit2 `ack1`: rising edge acks half 1.
  - bit3 `ovf_clr`: rising edge clears overflow.
  - bits 31:4 ignored.
- `s_valid` in 1: stream word valid.
- `s_data` in DATA_W: stream word.
- `s_ready` out 1: block accepts a word when `s_valid & s_ready`.
- `bram_we` out 1: BRAM write enable.
- `bram_addr` out ADDR_W: BRAM write address.
- `bram_wdata` out DATA_W: BRAM write data.
- `status` out 32: to PIO `in_port`.
  - bit0 `full0`
  - bit1 `full1`
  - bit2 `overflow`
  - bit3 `running`
  - bits [16+ADDR_W-1:16] write pointer
  - all other bits 0

## Operation
- **States:** IDLE, FILL0, FILL1, STALL. STALL records the target half.
- **Reset:** state IDLE, `wptr`=0, all flags 0. All outputs are 0, including `status`, `bram_*` and `s_ready`.
- **IDLE:**
  - `s_ready`=0.
  - When `enable`=1, go to FILL0 with `wptr`=0.
- **FILL0 / FILL1:**
  - `s_ready`=1.
  - Each handshake writes `s_data` at `wptr`, then increments `wptr` modulo 2^ADDR_W.
  - A handshake at the last word of a half (low ADDR_W-1 bits all 1) sets that half's internal `full` flag.
  - After the last word, go to FILL of the other half if that half's flag is clear (evaluated after same-cycle acks). Otherwise go to STALL targeting the other half.
  - `wptr` wraps from 2^ADDR_W-1 to 0.
- **STALL:**
  - `s_ready`=0.
  - `s_valid`=1 sets `overflow` (sticky).
  - Go to FILL of the target half in the cycle after its flag clears.
- **Ack:** `ackN_pulse = ctrl[N] & ~ctrl_q[N]`.
  - The pulse clears `fullN`.
  - An ack to a half whose flag is already 0 is ignored.
  - An ack in the same cycle that sets that half's flag is ignored: set wins.
- **`ovf_clr` pulse:** clears `overflow`. If a set occurs in the same cycle, set wins.
- **`enable` dropped in any state:**
  - Next cycle: IDLE, `wptr`=0, `full0`/`full1` cleared.
  - `overflow` is retained.
  - Any write already registered in `bram_*` still completes.
- **`running`:** 1 in every state except IDLE.

## Timing
- `s_ready` is a function of the registered state only; no combinational path from `s_valid`.
- **Write latency:** handshake in cycle N → `bram_we`/`bram_addr`/`bram_wdata` registered, asserted in cycle N+1 for exactly one cycle.
- **Full flag:** the internal flag sets at the end of N. `status` is a registered copy of internal flags, so `status.fullN` is visible at N+2, after the BRAM write has committed.
- **Ack:** `ctrl` changes in cycle M → internal flag clears at the end of M → `status` reflects it at M+2.
  - A STALL targeting that half leaves at the end of M+1.
  - `s_ready`=1 from M+2.
- **Back-to-back:** one word per cycle sustained while not stalled. No bubble at the half boundary if the next half is free.
- **Latencies:** `status` overflow, running and wptr fields share the same 1-cycle register after internal state.

## Structure
- Package `f2s_fill_pkg`:
  - state enum
  - `CTRL_EN`/`CTRL_ACK0`/`CTRL_ACK1`/`CTRL_OVF_CLR` bit indices
  - `ST_FULL0`/`ST_FULL1`/`ST_OVF`/`ST_RUN`/`ST_WPTR_LSB` indices
- One sub-module `f2s_rise_det`: parameterised-width register plus `d & ~q` pulse, used on `ctrl[3:1]`.

## Test plan
All scenarios use ADDR_W=4 (16 words, 8-word halves).

1. **Reset:** assert `reset_n`=0 mid-fill at `wptr`=5 → next cycle all outputs 0, state IDLE. After release with `enable`=1, the first write goes to addr 0.
2. **Continuous stream:** `enable`=1, continuous `s_valid` with data 0..7 → `bram_we` at addr 0..7 with data 0..7, each one cycle after its handshake. `status[0]`=1 two cycles after the 8th handshake; writes continue at addr 8 with no gap.
3. **Stall and release:** fill all 16 words without acks → `s_ready`=0 after word 15, `status[1:0]`=11. Hold `s_valid`=1 → `status[2]`=1. Toggle `ack0` → `s_ready`=1 two cycles later, next write at addr 0.
4. **Simultaneous ack and completion:** `ack1` rising edge in the same cycle as the word-7 handshake, with `full1`=1 → no stall, word 8 accepted next cycle, `status[1]`=0.
5. **Redundant ack / set-wins:** `ack0` toggled while `full0`=0 → no effect. `ovf_clr` edge in the same cycle as an overflow set → `status[2]` stays 1.
6. **Enable drop:** drop `enable` at `wptr`=11 with `full0`=1 and `overflow`=1 → IDLE, `status` = 0x0000_0004 two cycles later. Re-enable → writes restart at addr 0.

Source files
------------

// File: rtl/f2s_bram_fill_ctrl_pkg.sv
// Shared types and bit-field indices for the f2s stream-to-BRAM fill controller.
package f2s_fill_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL0 = 2'd1,
    S_FILL1 = 2'd2,
    S_STALL = 2'd3
  } fill_state_e;

  localparam int unsigned CTRL_EN      = 0;
  localparam int unsigned CTRL_ACK0    = 1;
  localparam int unsigned CTRL_ACK1    = 2;
  localparam int unsigned CTRL_OVF_CLR = 3;

  localparam int unsigned ST_FULL0    = 0;
  localparam int unsigned ST_FULL1    = 1;
  localparam int unsigned ST_OVF      = 2;
  localparam int unsigned ST_RUN      = 3;
  localparam int unsigned ST_WPTR_LSB = 16;

endpackage

// File: rtl/f2s_bram_fill_ctrl_rise_det.sv
// Registered rising-edge detector: one-cycle pulse on each 0->1 transition of d.
module f2s_rise_det #(
  parameter int unsigned W = 3
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] pulse
);

  logic [W-1:0] d_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      d_q <= '0;
    end else begin
      d_q <= d;
    end
  end

  assign pulse = d & ~d_q;

endmodule

// File: rtl/f2s_bram_fill_ctrl.sv
// Ping-pong BRAM fill controller: writes a valid/ready stream into two halves
// and reports per-half full flags, overflow and write pointer to the HPS PIO.
module f2s_bram_fill_ctrl
  import f2s_fill_pkg::*;
#(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [31:0]       ctrl,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  output logic              bram_we,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [DATA_W-1:0] bram_wdata,
  output logic [31:0]       status
);

  fill_state_e       state_q, state_d;
  logic              stall_half_q, stall_half_d;
  logic [ADDR_W-1:0] wptr_q, wptr_d;
  logic [1:0]        full_q, full_d;
  logic              ovf_q, ovf_d;
  logic              bram_we_q, bram_we_d;
  logic [ADDR_W-1:0] bram_addr_q, bram_addr_d;
  logic [DATA_W-1:0] bram_wdata_q, bram_wdata_d;
  logic [31:0]       status_q, status_d;

  logic [2:0] ctrl_pulse;
  logic       enable, ack0, ack1, ovf_clr;
  logic       hs, last_word, cur_half, other_half;
  logic       ctrl_unused;

  f2s_rise_det #(.W(3)) u_ctrl_edges (
    .clk    (clk),
    .reset_n(reset_n),
    .d      (ctrl[CTRL_OVF_CLR:CTRL_ACK0]),
    .pulse  (ctrl_pulse)
  );

  assign ctrl_unused = ^ctrl[31:CTRL_OVF_CLR+1];

  assign enable  = ctrl[CTRL_EN];
  assign ack0    = ctrl_pulse[CTRL_ACK0-CTRL_ACK0];
  assign ack1    = ctrl_pulse[CTRL_ACK1-CTRL_ACK0];
  assign ovf_clr = ctrl_pulse[CTRL_OVF_CLR-CTRL_ACK0];

  assign s_ready    = (state_q == S_FILL0) || (state_q == S_FILL1);
  assign hs         = s_valid & s_ready;
  assign cur_half   = wptr_q[ADDR_W-1];
  assign other_half = ~cur_half;
  assign last_word  = &wptr_q[ADDR_W-2:0];

  always_comb begin
    state_d      = state_q;
    stall_half_d = stall_half_q;
    wptr_d       = wptr_q;
    full_d       = full_q;
    ovf_d        = ovf_q;
    bram_we_d    = 1'b0;
    bram_addr_d  = bram_addr_q;
    bram_wdata_d = bram_wdata_q;

    // Clears are applied before sets so a same-cycle set wins.
    if (ack0)    full_d[0] = 1'b0;
    if (ack1)    full_d[1] = 1'b0;
    if (ovf_clr) ovf_d     = 1'b0;

    if (hs) begin
      bram_we_d    = 1'b1;
      bram_addr_d  = wptr_q;
      bram_wdata_d = s_data;
      wptr_d       = wptr_q + ADDR_W'(1);
      if (last_word) full_d[cur_half] = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (enable) begin
          state_d = S_FILL0;
          wptr_d  = '0;
        end
      end
      S_FILL0, S_FILL1: begin
        if (hs && last_word) begin
          if (!full_d[other_half]) begin
            state_d = other_half ? S_FILL1 : S_FILL0;
          end else begin
            state_d      = S_STALL;
            stall_half_d = other_half;
          end
        end
      end
      S_STALL: begin
        if (s_valid) ovf_d = 1'b1;
        // Registered flag: leave one cycle after the ack has cleared it.
        if (!full_q[stall_half_q]) begin
          state_d = stall_half_q ? S_FILL1 : S_FILL0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (!enable) begin
      state_d = S_IDLE;
      wptr_d  = '0;
      full_d  = '0;
    end
  end

  always_comb begin
    status_d                            = '0;
    status_d[ST_FULL0]                  = full_q[0];
    status_d[ST_FULL1]                  = full_q[1];
    status_d[ST_OVF]                    = ovf_q;
    status_d[ST_RUN]                    = (state_q != S_IDLE);
    status_d[ST_WPTR_LSB +: ADDR_W]     = wptr_q;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      stall_half_q <= 1'b0;
      wptr_q       <= '0;
      full_q       <= '0;
      ovf_q        <= 1'b0;
      bram_we_q    <= 1'b0;
      bram_addr_q  <= '0;
      bram_wdata_q <= '0;
      status_q     <= '0;
    end else begin
      state_q      <= state_d;
      stall_half_q <= stall_half_d;
      wptr_q       <= wptr_d;
      full_q       <= full_d;
      ovf_q        <= ovf_d;
      bram_we_q    <= bram_we_d;
      bram_addr_q  <= bram_addr_d;
      bram_wdata_q <= bram_wdata_d;
      status_q     <= status_d;
    end
  end

  assign bram_we    = bram_we_q;
  assign bram_addr  = bram_addr_q;
  assign bram_wdata = bram_wdata_q;
  assign status     = status_q;

endmodule

// File: tb/tb_f2s_bram_fill_ctrl.sv
// Self-checking bench for f2s_bram_fill_ctrl (ADDR_W=4): per-cycle vector table
// for s_ready/status plus a write scoreboard for the BRAM port.
module tb_f2s_bram_fill_ctrl;

  localparam int unsigned AW = 4;
  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [31:0]   ctrl;
  logic          s_valid;
  logic [DW-1:0] s_data;
  logic          s_ready;
  logic          bram_we;
  logic [AW-1:0] bram_addr;
  logic [DW-1:0] bram_wdata;
  logic [31:0]   status;

  f2s_bram_fill_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .ctrl      (ctrl),
    .s_valid   (s_valid),
    .s_data    (s_data),
    .s_ready   (s_ready),
    .bram_we   (bram_we),
    .bram_addr (bram_addr),
    .bram_wdata(bram_wdata),
    .status    (status)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] ctrl;
    logic        valid;
    logic [31:0] data;
    logic        exp_ready;
    logic [31:0] exp_status;
  } vec_t;

  typedef struct {
    int unsigned   due;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  vec_t        vecs[$];
  wr_t         sb[$];
  int unsigned cyc = 0;
  logic [AW-1:0] model_wptr = '0;
  int          n_checks = 0;
  int          n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void add(input logic [31:0] c, input logic v, input logic [31:0] d,
                              input logic r, input logic [31:0] st);
    vec_t x;
    x.ctrl = c; x.valid = v; x.data = d; x.exp_ready = r; x.exp_status = st;
    vecs.push_back(x);
  endfunction

  // Records the handshake about to be taken at the next edge, advances a cycle,
  // then retires any BRAM write against the scoreboard.
  task automatic tick();
    wr_t e;
    if (reset_n && s_valid && s_ready) begin
      e.due = cyc + 1; e.addr = model_wptr; e.data = s_data;
      sb.push_back(e);
      model_wptr = model_wptr + 1'b1;
    end
    if (!reset_n) begin
      sb.delete();
      model_wptr = '0;
    end else if (!ctrl[0]) begin
      model_wptr = '0;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (bram_we) begin
      if (sb.size() == 0) begin
        check("wr_unexpected", 32'(bram_we), 32'd0);
      end else begin
        e = sb.pop_front();
        check("wr_latency", cyc, e.due);
        check("wr_addr", 32'(bram_addr), 32'(e.addr));
        check("wr_data", bram_wdata, e.data);
      end
    end else if (sb.size() > 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      check("wr_missing", 32'(bram_we), 32'd1);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Continuous stream over both halves, then stall with overflow.
    add(1, 0, 0, 1, 32'h0);
    for (int a = 0; a < 8; a++)  add(1, 1, a, 1, 32'h8 | (a << 16));
    for (int a = 8; a < 16; a++) add(1, 1, a, (a != 15), 32'h9 | (a << 16));
    add(1, 1, 100, 0, 32'hB);
    add(1, 1, 101, 0, 32'hF);
    add(3, 0, 0, 0, 32'hF);
    add(3, 0, 0, 1, 32'hE);
    add(3, 1, 200, 1, 32'hE);
    // ack1 edge coincides with the last word of half 0.
    for (int a = 1; a < 7; a++) add(1, 1, 200 + a, 1, 32'hE | (a << 16));
    add(5, 1, 207, 1, 32'h0007_000E);
    add(5, 1, 208, 1, 32'h0008_000D);
    // Clear full0, redundant ack0, then clear overflow.
    add(7, 0, 0, 1, 32'h0009_000D);
    add(1, 0, 0, 1, 32'h0009_000C);
    add(3, 0, 0, 1, 32'h0009_000C);
    add(1, 0, 0, 1, 32'h0009_000C);
    add(9, 0, 0, 1, 32'h0009_000C);
    add(1, 0, 0, 1, 32'h0009_0008);
    // Fill to a stall on half 1, then ovf_clr together with an overflow set.
    for (int a = 9; a < 16; a++) add(1, 1, 300 + a, 1, 32'h8 | (a << 16));
    for (int a = 0; a < 8; a++)  add(1, 1, 300 + a, (a != 7), 32'hA | (a << 16));
    add(9, 1, 400, 0, 32'h0008_000B);
    add(1, 0, 0, 0, 32'h0008_000F);
    add(5, 0, 0, 0, 32'h0008_000F);
    add(1, 0, 0, 1, 32'h0008_000D);
    // Enable dropped at wptr=11, then re-enabled.
    for (int a = 8; a < 11; a++) add(1, 1, 500 + a, 1, 32'hD | (a << 16));
    add(0, 0, 0, 0, 32'h000B_000D);
    add(0, 0, 0, 0, 32'h4);
    add(1, 0, 0, 1, 32'h4);
    add(1, 1, 600, 1, 32'hC);
    for (int a = 1; a < 5; a++) add(1, 1, 600 + a, 1, 32'hC | (a << 16));

    reset_n = 1'b0; ctrl = '0; s_valid = 1'b0; s_data = '0;
    repeat (3) tick();
    check("rst_ready", 32'(s_ready), 0);
    check("rst_we", 32'(bram_we), 0);
    check("rst_status", status, 0);
    reset_n = 1'b1;
    tick();

    foreach (vecs[i]) begin
      ctrl = vecs[i].ctrl; s_valid = vecs[i].valid; s_data = vecs[i].data;
      tick();
      check($sformatf("row%0d_ready", i), 32'(s_ready), 32'(vecs[i].exp_ready));
      check($sformatf("row%0d_status", i), status, vecs[i].exp_status);
    end

    // Reset mid-fill at wptr=5: every output returns to 0.
    reset_n = 1'b0; ctrl = 1; s_valid = 1'b1; s_data = 32'hDEAD;
    tick();
    check("midrst_ready", 32'(s_ready), 0);
    check("midrst_we", 32'(bram_we), 0);
    check("midrst_addr", 32'(bram_addr), 0);
    check("midrst_wdata", bram_wdata, 0);
    check("midrst_status", status, 0);
    reset_n = 1'b1; s_valid = 1'b0;
    tick();
    check("post_rst_ready", 32'(s_ready), 1);
    check("post_rst_status", status, 0);
    s_valid = 1'b1; s_data = 32'hABCD;
    tick();
    check("post_rst_status_run", status, 32'h8);
    s_valid = 1'b0;
    tick();
    tick();
    check("sb_drain", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
